// File: rtl/cam_capture_if.sv
// RAM write port between the camera capture block and the frame buffer.
interface cam_capture_if #(
  parameter int AW = 15
);
  logic [AW-1:0] DP_RAM_addr_in;
  logic [11:0]   DP_RAM_data_in;
  logic          DP_RAM_regW;

  modport master (
    output DP_RAM_addr_in,
    output DP_RAM_data_in,
    output DP_RAM_regW
  );

  modport slave (
    input DP_RAM_addr_in,
    input DP_RAM_data_in,
    input DP_RAM_regW
  );
endinterface

// File: rtl/cam_capture.sv
// Camera frame capture: turns the two-byte-per-pixel camera stream into
// 12-bit pixels written into a dual-port frame buffer. Supports photo
// snapshot (freeze after one frame) and continuous video.
module cam_capture #(
  parameter int AW      = 15,
  parameter int H_PIX   = 160,
  parameter int V_LINES = 120
) (
  input  logic          CAM_PCLK,
  input  logic          rst,
  input  logic          CAM_VSYNC,
  input  logic          CAM_HREF,
  input  logic [7:0]    CAM_px_data,
  input  logic [1:0]    fmt_sel,
  input  logic          Photo_button,
  input  logic          Video_button,
  cam_capture_if.master ram,
  output logic          frame_done,
  output logic [7:0]    frame_cnt,
  output logic          line_err,
  output logic          frozen
);

  localparam int PW = $clog2(H_PIX + 1);
  localparam int LW = $clog2(V_LINES + 1);
  localparam logic [PW-1:0] H_MAX  = PW'(H_PIX);
  localparam logic [LW-1:0] V_MAX  = LW'(V_LINES);
  localparam logic [AW-1:0] H_STEP = AW'(H_PIX);

  if (longint'(H_PIX) * longint'(V_LINES) > (longint'(1) << AW)) begin : g_size_check
    $error("cam_capture: H_PIX*V_LINES does not fit in the RAM address space");
  end

  typedef enum logic [1:0] {IDLE, WAIT_LINE, LINE, FROZEN} state_e;

  state_e        state_q, state_d;
  logic          vsync_prev_q, vsync_prev_d;
  logic          href_prev_q, href_prev_d;
  logic [1:0]    fmt_q, fmt_d;
  logic          phase_q, phase_d;
  // Only the first-byte bits any format uses: {b0[7:4], b0[2:0]}
  logic [6:0]    byte0_q, byte0_d;
  logic [PW-1:0] pixel_q, pixel_d;
  logic [LW-1:0] line_q, line_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] line_base_q, line_base_d;
  logic          wrote_any_q, wrote_any_d;
  logic          arm_q, arm_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [11:0]   ram_data_q, ram_data_d;
  logic          ram_regw_q, ram_regw_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          line_err_q, line_err_d;
  logic          frozen_q, frozen_d;
  logic [11:0]   pix_word;

  // Pack the held first byte and the current second byte into 12 bits
  always_comb begin
    pix_word = '0;
    case (fmt_q)
      2'b01:   pix_word = {4'b0000, byte0_q[6:4], byte0_q[2:0], CAM_px_data[4:3]};
      2'b10:   pix_word = {3{byte0_q[6:3]}};
      default: pix_word = {byte0_q, CAM_px_data[7], CAM_px_data[4:1]};
    endcase
  end

  // Next-state and next-output computation for the capture FSM
  always_comb begin
    state_d      = state_q;
    vsync_prev_d = CAM_VSYNC;
    href_prev_d  = CAM_HREF;
    fmt_d        = fmt_q;
    phase_d      = phase_q;
    byte0_d      = byte0_q;
    pixel_d      = pixel_q;
    line_d       = line_q;
    wr_ptr_d     = wr_ptr_q;
    line_base_d  = line_base_q;
    wrote_any_d  = wrote_any_q;
    arm_d        = arm_q;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    ram_regw_d   = 1'b0;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    line_err_d   = line_err_q;

    if (state_q != FROZEN) begin
      if (Video_button) begin
        arm_d = 1'b0;
      end else if (Photo_button) begin
        arm_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (vsync_prev_q && !CAM_VSYNC) begin
          state_d     = WAIT_LINE;
          fmt_d       = (fmt_sel == 2'b11) ? 2'b00 : fmt_sel;
          wr_ptr_d    = '0;
          line_base_d = '0;
          ram_addr_d  = '0;
          line_d      = '0;
          pixel_d     = '0;
          phase_d     = 1'b0;
          line_err_d  = 1'b0;
          wrote_any_d = 1'b0;
        end
      end
      WAIT_LINE, LINE: begin
        if (CAM_VSYNC) begin
          if (wrote_any_q) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 8'd1;
          end
          state_d = (wrote_any_q && arm_d) ? FROZEN : IDLE;
        end else if (state_q == WAIT_LINE) begin
          if (CAM_HREF && !href_prev_q) begin
            state_d = LINE;
            byte0_d = {CAM_px_data[7:4], CAM_px_data[2:0]};
            phase_d = 1'b1;
            pixel_d = '0;
          end
        end else if (!CAM_HREF) begin
          state_d = WAIT_LINE;
          phase_d = 1'b0;
          pixel_d = '0;
          if (line_q < V_MAX) begin
            if (pixel_q < H_MAX) begin
              line_err_d = 1'b1;
            end
            wr_ptr_d    = line_base_q + H_STEP;
            line_base_d = line_base_q + H_STEP;
            line_d      = line_q + 1'b1;
          end
        end else if (!phase_q) begin
          byte0_d = {CAM_px_data[7:4], CAM_px_data[2:0]};
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if ((pixel_q < H_MAX) && (line_q < V_MAX)) begin
            ram_regw_d  = 1'b1;
            ram_addr_d  = wr_ptr_q;
            ram_data_d  = pix_word;
            wr_ptr_d    = wr_ptr_q + 1'b1;
            pixel_d     = pixel_q + 1'b1;
            wrote_any_d = 1'b1;
          end
        end
      end
      FROZEN: begin
        if (Video_button) begin
          state_d = IDLE;
          arm_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    frozen_d = (state_d == FROZEN);
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge CAM_PCLK) begin
    if (rst) begin
      state_q      <= IDLE;
      vsync_prev_q <= 1'b0;
      href_prev_q  <= 1'b0;
      fmt_q        <= 2'b00;
      phase_q      <= 1'b0;
      byte0_q      <= '0;
      pixel_q      <= '0;
      line_q       <= '0;
      wr_ptr_q     <= '0;
      line_base_q  <= '0;
      wrote_any_q  <= 1'b0;
      arm_q        <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      ram_regw_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      line_err_q   <= 1'b0;
      frozen_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_prev_q <= vsync_prev_d;
      href_prev_q  <= href_prev_d;
      fmt_q        <= fmt_d;
      phase_q      <= phase_d;
      byte0_q      <= byte0_d;
      pixel_q      <= pixel_d;
      line_q       <= line_d;
      wr_ptr_q     <= wr_ptr_d;
      line_base_q  <= line_base_d;
      wrote_any_q  <= wrote_any_d;
      arm_q        <= arm_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      ram_regw_q   <= ram_regw_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      line_err_q   <= line_err_d;
      frozen_q     <= frozen_d;
    end
  end

  assign ram.DP_RAM_addr_in = ram_addr_q;
  assign ram.DP_RAM_data_in = ram_data_q;
  assign ram.DP_RAM_regW    = ram_regw_q;
  assign frame_done         = frame_done_q;
  assign frame_cnt          = frame_cnt_q;
  assign line_err           = line_err_q;
  assign frozen             = frozen_q;

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter AW, default 15, RAM address width.
REQ-002 Parameter H_PIX, default 160, stored pixels per line.
REQ-003 Parameter V_LINES, default 120, stored lines per frame; H_PIX*V_LINES SHALL NOT exceed 2^AW (elaboration error otherwise).
REQ-004 CAM_PCLK  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 CAM_VSYNC  in  1  frame sync, high between frames.
REQ-007 CAM_HREF  in  1  line valid, high while bytes valid.
REQ-008 CAM_px_data  in  8  camera byte, two bytes per pixel.
REQ-009 fmt_sel  in  2  00 RGB565->RGB444, 01 RGB565->RGB332, 10 YUV422->gray, 11 reserved (treated as 00).
REQ-010 Photo_button  in  1  level, request single-frame snapshot.
REQ-011 Video_button  in  1  level, request continuous video.
REQ-012 DP_RAM_addr_in  out  AW  write address.
REQ-013 DP_RAM_data_in  out  12  write data.
REQ-014 DP_RAM_regW  out  1  write strobe, one cycle per pixel.
REQ-015 frame_done  out  1  one-cycle pulse at end of a captured frame.
REQ-016 frame_cnt  out  8  captured frames, wraps 255->0.
REQ-017 line_err  out  1  sticky, set on short line; cleared by rst or next frame start.
REQ-018 frozen  out  1  high while snapshot held.

Function
REQ-019 States: IDLE (wait frame start), WAIT_LINE (wait HREF rise), LINE (capture), FROZEN.
REQ-020 IDLE->WAIT_LINE on VSYNC falling edge (registered previous VSYNC high, current low); on entry addr=0, line=0, line_err=0.
REQ-021 WAIT_LINE->LINE on HREF rising edge; first byte of that cycle SHALL be latched as byte 0.
REQ-022 LINE: bytes alternate byte0/byte1 via phase bit; on byte1 cycle, if pixel<H_PIX and line<V_LINES, regW=1 for exactly that cycle with data per REQ-023, then addr+1, pixel+1; otherwise regW=0, nothing advances.
REQ-023 Packing (b0 first byte, b1 second): RGB444 = {b0[7:4], b0[2:0],b1[7], b1[4:1]}; RGB332 = {4'b0, b0[7:5], b0[2:0], b1[4:3]}; gray = {b0[7:4], b0[7:4], b0[7:4]}.
REQ-024 LINE->WAIT_LINE on HREF low; if line<V_LINES and pixel<H_PIX, set line_err and force addr=(line+1)*H_PIX (computed by accumulation, no multiplier); a dangling byte0 SHALL be discarded; line+1 (saturate at V_LINES).
REQ-025 Pixels beyond H_PIX and lines beyond V_LINES discarded; addr SHALL never exceed H_PIX*V_LINES-1.
REQ-026 VSYNC high in WAIT_LINE or LINE ends frame: if at least one pixel written, frame_done pulses next cycle and frame_cnt+1; then ->IDLE, or ->FROZEN if snapshot armed.
REQ-027 Snapshot: Photo_button high in any non-FROZEN state arms snapshot; current/next completed frame ends in FROZEN; aborted (zero-pixel) frames do not count.
REQ-028 FROZEN: regW=0, frozen=1, camera inputs ignored; Video_button ->IDLE, clears arm.
REQ-029 Video_button and Photo_button both high same cycle: Video_button wins, arm cleared.
REQ-030 fmt_sel sampled at frame start (IDLE->WAIT_LINE) and held for the frame.
REQ-031 regW, data, addr registered; regW asserted in cycle after byte1 with matching addr/data.

Reset
REQ-032 On rst high at clock edge, regardless of state: state=IDLE, addr=0, data=0, regW=0, frame_done=0, frame_cnt=0, line_err=0, frozen=0, arm cleared, prev VSYNC=0.
REQ-033 rst mid-line SHALL produce no further regW until a full new VSYNC falling edge.

Verification
REQ-034 Full 160x120 RGB565 frame, fmt 00, b0=8'hF8,b1=8'h1F -> 19200 writes, addr 0..19199, data 12'hF0F, frame_done once, frame_cnt=1.
REQ-035 Line of 200 pixels -> only 160 writes, line ends at addr 159, next line starts at 160, line_err=0.
REQ-036 Line 3 of 100 pixels -> line_err=1, line 4 first write at addr 640.
REQ-037 Photo_button pulse mid-frame -> frame completes, frozen=1, next frame zero writes; Video_button -> resumes at next VSYNC fall.
REQ-038 rst asserted at pixel 50 of line 10 -> regW=0 next cycle, frame_cnt=0, first write after next VSYNC fall at addr 0.
REQ-039 fmt 10, bytes Y=8'hA5,U=8'h33 -> data 12'hAAA; fmt 01 b0=8'hE0,b1=8'h18 -> data 12'h0E3.
